next_pc_unit: RTL and testbench

//  Program-counter register plus next-PC selection for the single-cycle CPU, with

---
 rtl/next_pc_unit.sv | 124 ++++++++++++
 tb/tb_next_pc_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Program counter with stall, next-PC select (Ret > Jr > Jump > Bzero > PC4)
// and a circular return-address stack for call/return.
module next_pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic [31:0]      Instr,
  input  logic [WIDTH-1:0] imm,
  input  logic             Bzero,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Jr,
  input  logic [WIDTH-1:0] rs_val,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic [WIDTH-1:0] jumpPC,
  output logic [WIDTH-1:0] Bimm,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  // At WIDTH=28 the shift wraps to 0, so the mask becomes all ones.
  localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << 28) - WIDTH'(1);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_jump;
  logic [WIDTH-1:0] w_bimm;
  logic [WIDTH-1:0] w_rs_al;
  logic [WIDTH-1:0] w_instr_sh;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_next;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_ptr_dec;
  logic             w_empty;
  logic             w_full;
  logic             w_call;
  logic             w_wr_en;
  logic [PW-1:0]    w_wr_idx;

  assign w_pc4      = r_pc + WIDTH'(4);
  assign w_instr_sh = WIDTH'({Instr, 2'b00});
  assign w_jump     = (r_pc & ~LOW_MASK) | (w_instr_sh & LOW_MASK);
  assign w_bimm     = imm << 2;
  assign w_rs_al    = rs_val & ~WIDTH'(3);

  assign w_ptr_inc = (r_ptr == PW'(RAS_DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  assign w_ptr_dec = (r_ptr == '0) ? PW'(RAS_DEPTH - 1) : r_ptr - PW'(1);
  assign w_top     = r_stack[w_ptr_dec];
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(RAS_DEPTH));
  assign w_call    = Jump & Call;

  always_comb begin
    w_next = w_pc4;
    if (Ret)        w_next = w_empty ? w_rs_al : w_top;
    else if (Jr)    w_next = w_rs_al;
    else if (Jump)  w_next = w_jump;
    else if (Bzero) w_next = w_pc4 + w_bimm;
  end

  // A swap on a non-empty stack rewrites the top slot; every other push writes at ptr.
  always_comb begin
    w_wr_en  = en & w_call;
    w_wr_idx = (Ret && !w_empty) ? w_ptr_dec : r_ptr;
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_stack[w_wr_idx] <= w_pc4;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (en) begin
      r_pc <= w_next;
      if (Ret) begin
        if (w_empty) begin
          r_unf <= 1'b1;
          if (w_call) begin
            r_ptr <= w_ptr_inc;
            r_cnt <= CW'(1);
          end
        end else if (!w_call) begin
          r_ptr <= w_ptr_dec;
          r_cnt <= r_cnt - CW'(1);
        end
      end else if (w_call) begin
        r_ptr <= w_ptr_inc;
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign PC        = r_pc;
  assign PC4       = w_pc4;
  assign jumpPC    = w_jump;
  assign Bimm      = w_bimm;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: reset, stall, branch/jump, call/return,
// RAS overflow/underflow and simultaneous-select priority.
module tb_next_pc_unit;

  logic        CLK;
  logic        reset;
  logic        en;
  logic [31:0] Instr;
  logic [31:0] imm;
  logic        Bzero, Jump, Call, Ret, Jr;
  logic [31:0] rs_val;
  logic [31:0] PC, PC4, jumpPC, Bimm;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  next_pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .en(en), .Instr(Instr), .imm(imm),
    .Bzero(Bzero), .Jump(Jump), .Call(Call), .Ret(Ret), .Jr(Jr),
    .rs_val(rs_val), .PC(PC), .PC4(PC4), .jumpPC(jumpPC), .Bimm(Bimm),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Bzero = 1'b0; Jump = 1'b0; Call = 1'b0; Ret = 1'b0; Jr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; idle();
    Instr = '0; imm = '0; rs_val = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_empty", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_ovf", ras_ovf, 0);
    chk("rst_unf", ras_unf, 0);
    reset = 1'b1; en = 1'b1;

    // sequential then stall
    tick(); chk("seq1", PC, 32'h4);
    tick(); chk("seq2", PC, 32'h8);
    tick(); chk("seq3", PC, 32'hC);
    chk("pc4", PC4, 32'h10);
    en = 1'b0;
    tick(); tick(); chk("stall", PC, 32'hC);
    en = 1'b1;

    // mid-run async reset at PC=0x40 with a live RAS entry
    Jr = 1'b1; rs_val = 32'h3E;
    tick(); chk("jr_align", PC, 32'h3C);
    idle(); Jump = 1'b1; Call = 1'b1; Instr = 32'h10;
    tick(); chk("pre_rst_pc", PC, 32'h40);
    chk("pre_rst_empty", ras_empty, 0);
    idle(); en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_pc", PC, 32'h0);
    chk("async_empty", ras_empty, 1);
    chk("async_ovf", ras_ovf, 0);
    reset = 1'b1; en = 1'b1;

    // branch and jump
    Jr = 1'b1; rs_val = 32'h100;
    tick(); chk("jr100", PC, 32'h100);
    idle(); Bzero = 1'b1; imm = 32'h9876;
    #1 chk("bimm", Bimm, 32'h000261D8);
    tick(); chk("branch", PC, 32'h000262DC);
    idle(); Jr = 1'b1; rs_val = 32'h100;
    tick();
    idle(); Jump = 1'b1; Instr = 32'h12345678;
    #1 chk("jumppc", jumpPC, 32'h08D159E0);
    tick(); chk("jump", PC, 32'h08D159E0);

    // call / return
    idle(); Jr = 1'b1; rs_val = 32'h20;
    tick();
    idle(); Jump = 1'b1; Call = 1'b1; Instr = 32'h140;
    tick(); chk("call_pc", PC, 32'h500);
    chk("call_nonempty", ras_empty, 0);
    idle(); Ret = 1'b1;
    tick(); chk("ret_pc", PC, 32'h24);
    chk("ret_empty", ras_empty, 1);

    // overflow: five calls chained 0x0 -> 0x10 -> ... -> 0x50
    idle(); Jr = 1'b1; rs_val = 32'h0;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle(); Jump = 1'b1; Call = 1'b1; Instr = 32'((i + 1) * 4);
      tick();
      if (i == 3) begin
        chk("full4", ras_full, 1);
        chk("noovf4", ras_ovf, 0);
      end
    end
    chk("call5_pc", PC, 32'h50);
    chk("ovf", ras_ovf, 1);
    chk("full5", ras_full, 1);
    for (int k = 0; k < 4; k++) begin
      idle(); Ret = 1'b1;
      tick(); chk("pop", PC, 32'h44 - 32'(k * 16));
    end
    chk("pop_empty", ras_empty, 1);
    chk("pop_nounf", ras_unf, 0);
    rs_val = 32'h203;
    tick(); chk("unf_pc", PC, 32'h200);
    chk("unf", ras_unf, 1);
    chk("unf_empty", ras_empty, 1);

    // simultaneous selects
    idle(); Jr = 1'b1; rs_val = 32'h20;
    tick();
    idle(); Jump = 1'b1; Call = 1'b1; Instr = 32'h20;
    tick(); chk("call80", PC, 32'h80);
    idle(); Jump = 1'b1; Call = 1'b1; Ret = 1'b1; rs_val = 32'h999;
    tick(); chk("swap_pc", PC, 32'h24);
    chk("swap_cnt", ras_empty, 0);
    idle(); Ret = 1'b1; en = 1'b0;
    tick(); chk("stall_ret_pc", PC, 32'h24);
    chk("stall_ret_ras", ras_empty, 0);
    en = 1'b1;
    tick(); chk("swap_top", PC, 32'h84);
    chk("swap_pop_empty", ras_empty, 1);
    idle(); Jump = 1'b1; Call = 1'b1; Ret = 1'b1; rs_val = 32'h1003;
    tick(); chk("swap_empty_pc", PC, 32'h1000);
    chk("swap_empty_push", ras_empty, 0);
    idle(); Ret = 1'b1;
    tick(); chk("swap_empty_top", PC, 32'h88);
    chk("swap_empty_after", ras_empty, 1);
    idle(); Jr = 1'b1; Bzero = 1'b1; rs_val = 32'h3001; imm = 32'h5;
    tick(); chk("jr_bz", PC, 32'h3000);
    idle(); Call = 1'b1;
    tick(); chk("call_nojump_pc", PC, 32'h3004);
    chk("call_nojump_ras", ras_empty, 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
